// File: rtl/delta_neuron_pkg.sv
// NeuronPkg: width helpers and FSM encodings shared by the forward and
// backward neuron blocks.
package NeuronPkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } NeuronState;

    // Full-precision accumulator: product width plus growth for nc terms.
    function automatic int accWidth(input int wd, input int nc);
        return 2 * wd + $clog2(nc);
    endfunction

    function automatic int cntWidth(input int nc);
        return $clog2(nc);
    endfunction

endpackage

// File: rtl/delta_neuron_mac.sv
// DeltaMac: signed multiply-accumulate with synchronous clear and enable.
module DeltaMac #(
    parameter int WD = 4,
    parameter int AW = 11
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 iClr,
    input  logic                 iEn,
    input  logic signed [WD-1:0] iDelta,
    input  logic signed [WD-1:0] iWeight,
    output logic signed [AW-1:0] oAcc
);

    logic signed [2*WD-1:0] prod;
    logic signed [AW-1:0]   prodExt;

    // Both operands sign-extended to full product width before multiplying.
    assign prod    = $signed({{WD{iDelta[WD-1]}}, iDelta}) * $signed({{WD{iWeight[WD-1]}}, iWeight});
    assign prodExt = $signed({{(AW-2*WD){prod[2*WD-1]}}, prod});

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oAcc <= '0;
        end else if (iClr) begin
            oAcc <= '0;
        end else if (iEn) begin
            oAcc <= oAcc + prodExt;
        end
    end

endmodule

// File: rtl/delta_neuron.sv
// delta_neuron: back-propagates NC child deltas through their weights, one MAC per cycle.
// Optional macro DELTA_NEURON_SAT_EN selects saturating output reduction instead of wrap.
module delta_neuron
    import NeuronPkg::*;
#(
    parameter string HIDDEN = "yes",
    parameter int    NC     = 8,
    parameter int    WD     = 4
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 iValid_BS,
    output logic                 oReady_BS,
    input  logic [NC*WD-1:0]     iDelta_BS,
    input  logic                 iDeriv_BS,
    input  logic [NC*WD-1:0]     iWeight,
    output logic                 oValid_AS,
    input  logic                 iReady_AS,
    output logic signed [WD-1:0] oDelta_AS
);

    localparam int AW = accWidth(WD, NC);
    localparam int CW = cntWidth(NC);

    NeuronState state, nextState;

    logic [CW-1:0]        laneCnt;
    logic [NC*WD-1:0]     deltaReg, weightReg;
    logic                 derivReg;
    logic                 accept, lastLane, handshake, macEn;
    logic signed [WD-1:0] laneDelta, laneWeight, result;
    logic signed [AW-1:0] acc;

    function automatic logic signed [WD-1:0] reduceAcc(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] shifted;
        shifted = a >>> (WD - 1);
`ifdef DELTA_NEURON_SAT_EN
        if (shifted[AW-1:WD-1] == {(AW-WD+1){shifted[AW-1]}}) begin
            return shifted[WD-1:0];
        end else if (shifted[AW-1]) begin
            return {1'b1, {(WD-1){1'b0}}};
        end else begin
            return {1'b0, {(WD-1){1'b1}}};
        end
`else
        return shifted[WD-1:0];
`endif
    endfunction

    assign accept    = (state == IDLE) && iValid_BS && oReady_BS;
    assign lastLane  = (laneCnt == CW'(NC - 1));
    assign handshake = oValid_AS && iReady_AS;
    assign macEn     = (state == ACC);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept)    nextState = ACC;
            ACC:     if (lastLane)  nextState = OUT;
            OUT:     if (handshake) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Capture stage: operands frozen for the whole accumulation.
    always_ff @(posedge iCLK) begin
        if (accept) begin
            deltaReg  <= iDelta_BS;
            weightReg <= iWeight;
            derivReg  <= iDeriv_BS;
        end
    end

    assign laneDelta  = deltaReg[laneCnt*WD +: WD];
    assign laneWeight = weightReg[laneCnt*WD +: WD];

    // Accumulate stage: lane laneCnt is added on each ACC cycle.
    DeltaMac #(
        .WD(WD),
        .AW(AW)
    ) uMac (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iClr   (accept),
        .iEn    (macEn),
        .iDelta (laneDelta),
        .iWeight(laneWeight),
        .oAcc   (acc)
    );

    // Output stage: the finished accumulator is reduced one cycle after the last lane.
    assign result = ((HIDDEN == "yes") && !derivReg) ? '0 : reduceAcc(acc);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            laneCnt   <= '0;
            oReady_BS <= 1'b0;
            oValid_AS <= 1'b0;
            oDelta_AS <= '0;
        end else begin
            oReady_BS <= (nextState == IDLE);
            if (accept) begin
                laneCnt <= '0;
            end else if (state == ACC) begin
                laneCnt <= lastLane ? '0 : laneCnt + 1'b1;
            end
            if ((state == OUT) && !oValid_AS) begin
                oValid_AS <= 1'b1;
                oDelta_AS <= result;
            end else if (handshake) begin
                oValid_AS <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_delta_neuron.sv
// Testbench for delta_neuron (NC=8, WD=4): a HIDDEN="yes" and a HIDDEN="no" instance share stimulus.
module tb_delta_neuron;

    localparam int NC = 8;
    localparam int WD = 4;

    logic                 clk, rst;
    logic                 iValid, iDeriv, iReady;
    logic [NC*WD-1:0]     iDelta, iWeightV;
    logic                 readyY, validY, readyN, validN;
    logic signed [WD-1:0] deltaY, deltaN;

    int compares = 0;
    int errors   = 0;
    logic signed [WD-1:0] qY[$];
    logic signed [WD-1:0] qN[$];

    delta_neuron #(.HIDDEN("yes"), .NC(NC), .WD(WD)) dut (
        .iCLK(clk), .iRST(rst), .iValid_BS(iValid), .oReady_BS(readyY),
        .iDelta_BS(iDelta), .iDeriv_BS(iDeriv), .iWeight(iWeightV),
        .oValid_AS(validY), .iReady_AS(iReady), .oDelta_AS(deltaY)
    );

    delta_neuron #(.HIDDEN("no"), .NC(NC), .WD(WD)) dutNo (
        .iCLK(clk), .iRST(rst), .iValid_BS(iValid), .oReady_BS(readyN),
        .iDelta_BS(iDelta), .iDeriv_BS(iDeriv), .iWeight(iWeightV),
        .oValid_AS(validN), .iReady_AS(iReady), .oDelta_AS(deltaN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [NC*WD-1:0] lanes(input int a, input int b);
        logic [NC*WD-1:0] v;
        for (int c = 0; c < NC; c++) v[c*WD +: WD] = (c % 2 == 0) ? a[WD-1:0] : b[WD-1:0];
        return v;
    endfunction

    function automatic logic signed [WD-1:0] model(input logic [NC*WD-1:0] d, input logic [NC*WD-1:0] w,
                                                   input logic der, input bit hidden);
        int sum, sh;
        logic signed [WD-1:0] a, b, r;
        sum = 0;
        for (int c = 0; c < NC; c++) begin
            a = d[c*WD +: WD];
            b = w[c*WD +: WD];
            sum += int'(a) * int'(b);
        end
        sh = sum >>> (WD - 1);
`ifdef DELTA_NEURON_SAT_EN
        if (sh > 7) r = 4'sd7;
        else if (sh < -8) r = -4'sd8;
        else r = sh[WD-1:0];
`else
        r = sh[WD-1:0];
`endif
        if (hidden && !der) r = '0;
        return r;
    endfunction

    task automatic sendAndCheck(input logic [NC*WD-1:0] d, input logic [NC*WD-1:0] w,
                                input logic der, input int hold, input string name);
        int lat;
        logic signed [WD-1:0] eY, eN;
        lat = 0;
        while (!readyY && lat < 50) begin @(negedge clk); lat++; end
        compares++;
        if (readyY !== 1'b1) begin
            errors++;
            $display("FAIL %s ready: got %b want 1", name, readyY);
            return;
        end
        iValid = 1'b1; iDelta = d; iWeightV = w; iDeriv = der;
        qY.push_back(model(d, w, der, 1'b1));
        qN.push_back(model(d, w, der, 1'b0));
        @(posedge clk);
        @(negedge clk);
        iValid = 1'b0; iDelta = $urandom; iWeightV = $urandom; iDeriv = 1'($urandom_range(0, 1));
        lat = 0;
        while (!validY && lat < 20) begin @(negedge clk); lat++; end
        compares++;
        if (lat !== 9) begin errors++; $display("FAIL %s latency: got %0d want 9", name, lat); end
        compares++;
        if (validN !== 1'b1) begin errors++; $display("FAIL %s validNo: got %b want 1", name, validN); end
        eY = qY.pop_front();
        eN = qN.pop_front();
        compares++;
        if (deltaY !== eY) begin errors++; $display("FAIL %s deltaHidden: got %0d want %0d", name, deltaY, eY); end
        compares++;
        if (deltaN !== eN) begin errors++; $display("FAIL %s deltaOutLayer: got %0d want %0d", name, deltaN, eN); end
        for (int h = 0; h < hold; h++) begin
            iValid = 1'b1;
            @(negedge clk);
            compares++;
            if (validY !== 1'b1 || deltaY !== eY || readyY !== 1'b0) begin
                errors++;
                $display("FAIL %s hold%0d: valid=%b delta=%0d ready=%b want 1/%0d/0", name, h, validY, deltaY, readyY, eY);
            end
        end
        iValid = 1'b0;
        iReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iReady = 1'b0;
        compares++;
        if (readyY !== 1'b1 || validY !== 1'b0) begin
            errors++;
            $display("FAIL %s release: ready=%b valid=%b want 1/0", name, readyY, validY);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; iValid = 1'b0; iReady = 1'b0; iDeriv = 1'b0; iDelta = '0; iWeightV = '0;
        repeat (3) @(negedge clk);
        compares++;
        if (readyY !== 1'b0 || validY !== 1'b0 || deltaY !== 4'sd0 || readyN !== 1'b0 || validN !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs: ready=%b valid=%b delta=%0d want 0/0/0", readyY, validY, deltaY);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        compares++;
        if (readyY !== 1'b1 || readyN !== 1'b1) begin
            errors++;
            $display("FAIL reset release ready: got %b/%b want 1/1", readyY, readyN);
        end
    endtask

    task automatic test_basic();
        sendAndCheck(lanes(2, 2), lanes(3, 3), 1'b1, 0, "basic");
    endtask

    task automatic test_floor();
        sendAndCheck(lanes(7, -8), lanes(1, 1), 1'b1, 0, "floor");
    endtask

    task automatic test_overflow();
        sendAndCheck(lanes(7, 7), lanes(7, 7), 1'b1, 0, "overflowPos");
        sendAndCheck(lanes(-8, -8), lanes(7, 7), 1'b1, 0, "overflowNeg");
    endtask

    task automatic test_deriv();
        sendAndCheck(lanes(2, 2), lanes(3, 3), 1'b0, 0, "derivZero");
    endtask

    task automatic test_backpressure();
        bit sawValid;
        sendAndCheck(lanes(5, -3), lanes(2, 6), 1'b1, 5, "backpressure");
        sawValid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            sawValid |= (validY | validN);
        end
        compares++;
        if (sawValid !== 1'b0) begin errors++; $display("FAIL backpressure extraOutput: got 1 want 0"); end
    endtask

    task automatic test_reset_midop();
        bit sawValid;
        int lat;
        lat = 0;
        while (!readyY && lat < 50) begin @(negedge clk); lat++; end
        iValid = 1'b1; iDelta = lanes(2, 2); iWeightV = lanes(3, 3); iDeriv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iValid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        compares++;
        if (validY !== 1'b0 || readyY !== 1'b0 || validN !== 1'b0 || readyN !== 1'b0) begin
            errors++;
            $display("FAIL midReset immediate: valid=%b ready=%b want 0/0", validY, readyY);
        end
        @(negedge clk);
        rst = 1'b0;
        sawValid = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            sawValid |= (validY | validN);
        end
        compares++;
        if (sawValid !== 1'b0) begin errors++; $display("FAIL midReset spuriousOutput: got 1 want 0"); end
        compares++;
        if (readyY !== 1'b1) begin errors++; $display("FAIL midReset readyAfter: got %b want 1", readyY); end
        sendAndCheck(lanes(-2, 4), lanes(3, -5), 1'b1, 0, "afterReset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            sendAndCheck({$urandom}, {$urandom}, 1'($urandom_range(0, 1)), $urandom_range(0, 2), "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_floor();
        test_overflow();
        test_deriv();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
        $finish;
    end

endmodule

// File: doc/delta_neuron.md
DELTA_NEURON -- requirements
Module: delta_neuron

Interface
REQ-001 Parameter HIDDEN, default "yes": "yes" applies the activation-derivative gate; "no" ignores it (output-layer neuron).
REQ-002 Parameter NC, default 8: number of child neurons whose deltas are back-propagated; NC >= 2.
REQ-003 Parameter WD, default 4: signed width of each delta, each weight and the output delta; fixed point Q1.(WD-1).
REQ-004 iCLK  in  1  single clock; all state changes on the rising edge.
REQ-005 iRST  in  1  asynchronous, active-high reset.
REQ-006 iValid_BS  in  1  child-side delta vector valid.
REQ-007 oReady_BS  out  1  block can accept a delta vector.
REQ-008 iDelta_BS  in  NC*WD  signed child deltas; lane c at bits [c*WD +: WD].
REQ-009 iDeriv_BS  in  1  ReLU derivative of this neuron from the forward pass; sampled with iDelta_BS.
REQ-010 iWeight  in  NC*WD  signed weights to each child; lane c at bits [c*WD +: WD]; sampled with iDelta_BS.
REQ-011 oValid_AS  out  1  parent-side propagated delta valid.
REQ-012 iReady_AS  in  1  parent side accepts oDelta_AS.
REQ-013 oDelta_AS  out  WD  signed propagated delta.

Function
REQ-014 FSM states: IDLE, ACC, OUT; reset state is IDLE.
REQ-015 oReady_BS is registered and is 1 only in IDLE; it is 0 in ACC and OUT.
REQ-016 IDLE -> ACC on iValid_BS && oReady_BS; iDelta_BS, iWeight and iDeriv_BS are captured into registers and the accumulator is cleared.
REQ-017 ACC performs one signed product delta[c]*weight[c] per cycle, for c = 0..NC-1 in order; a counter of $clog2(NC) bits tracks c.
REQ-018 Accumulator width is AW = 2*WD + $clog2(NC); no internal overflow is possible.
REQ-019 After lane NC-1 the block enters OUT; oValid_AS rises exactly NC+1 cycles after the accepting edge.
REQ-020 Result = accumulator arithmetic-shifted right by WD-1 (floor toward minus infinity), reduced to WD bits per REQ-027/028.
REQ-021 If HIDDEN=="yes" and the captured iDeriv_BS is 0, oDelta_AS is 0; the latency is unchanged.
REQ-022 In OUT, oValid_AS and oDelta_AS hold stable until iReady_AS is 1; OUT -> IDLE on oValid_AS && iReady_AS.
REQ-023 iValid_BS is ignored outside IDLE; there is no back-to-back overlap, so throughput is one vector per NC+2 cycles at minimum.
REQ-024 iValid_BS is not required to stay asserted after the accept; iDelta_BS and iWeight may change freely after capture.

Reset
REQ-025 While iRST is 1: state is IDLE, the counter and accumulator are 0, oValid_AS = 0, oDelta_AS = 0 and oReady_BS = 0.
REQ-026 oReady_BS becomes 1 on the first rising edge after iRST falls; a reset asserted in ACC or OUT discards the operation and emits no output.

Configuration
REQ-027 With macro DELTA_NEURON_SAT_EN defined, the result saturates to [-2^(WD-1), 2^(WD-1)-1].
REQ-028 Without DELTA_NEURON_SAT_EN, the result is the low WD bits of the shifted accumulator (two's-complement wrap).

Structure
REQ-029 A shared package or header NeuronPkg holds the lane-width and accumulator-width functions (AW, counter width) and the FSM state encodings, for reuse by the forward Neuron.
REQ-030 One sub-module, DeltaMac, holds the signed multiply-accumulate with clear and enable; delta_neuron contains the FSM, the capture registers and the output reduction.

Verification (NC=8, WD=4)
REQ-031 All deltas 2, all weights 3, iDeriv_BS=1, accept at edge t -> oValid_AS=1 at edge t+9, oDelta_AS=6 (48>>>3) in both configurations.
REQ-032 Deltas alternating 7,-8 (lane 0 = 7), weights all 1, iDeriv_BS=1 -> oDelta_AS=-1 (-4>>>3, floor).
REQ-033 All deltas 7, all weights 7 -> accumulator 392, shifted 49; oDelta_AS=7 with DELTA_NEURON_SAT_EN, 1 without.
REQ-034 HIDDEN="yes", iDeriv_BS=0, deltas 2 and weights 3 -> oDelta_AS=0 at t+9; with HIDDEN="no" the same stimulus gives 6.
REQ-035 iReady_AS held 0 for 5 cycles in OUT -> oValid_AS and oDelta_AS stay stable, oReady_BS stays 0, a second iValid_BS is not accepted; on iReady_AS=1, oReady_BS=1 on the next edge.
REQ-036 iRST pulsed 1 at the 4th cycle of ACC -> oValid_AS and oReady_BS are 0 immediately, no output follows, and a new vector is accepted correctly after release.
